axi_r_burst_buffer: RTL and testbench

AXI_R_BURST_BUFFER -- requirements
Module: axi_r_burst_buffer

---
 rtl/axi_slice_pkg.sv | 16 +
 rtl/axi_buffer_ram.sv | 29 ++
 rtl/axi_r_burst_buffer.sv | 107 ++++++++++
 tb/tb_axi_r_burst_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
// Shared AXI R-channel definitions: response encodings and the packed beat width.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Stored beat layout is {id, user, data, resp[1:0], last}.
  function automatic int r_beat_width(input int data_w, input int user_w, input int id_w);
    return 3 + data_w + user_w + id_w;
  endfunction

endpackage

// File: rtl/axi_buffer_ram.sv
// Flat-width register file: one synchronous write port, one asynchronous read port.
module axi_buffer_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     test_en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Test enable only reaches the storage boundary; it carries no function here.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_r_burst_buffer.sv
// AXI R-channel beat buffer with optional store-and-forward release of whole bursts.
module axi_r_burst_buffer
  import axi_slice_pkg::*;
#(
  parameter  int ID_WIDTH     = 4,
  parameter  int DATA_WIDTH   = 64,
  parameter  int USER_WIDTH   = 6,
  parameter  int BUFFER_DEPTH = 8,
  parameter  int STORE_FWD    = 0,
  localparam int CNT_W        = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CNT_W-1:0]      fill_o,
  output logic [CNT_W-1:0]      bursts_o
);

  localparam int PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int BEAT_W = r_beat_width(DATA_WIDTH, USER_WIDTH, ID_WIDTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  bursts_q, bursts_d;
  logic [BEAT_W-1:0] wr_beat, rd_beat;
  logic              full, push, pop, push_last, pop_last;

  assign full           = (fill_q == CNT_W'(BUFFER_DEPTH));
  assign slave_ready_o  = (fill_q < CNT_W'(BUFFER_DEPTH));
  // Being full with no last stored forces release, else a long burst would deadlock.
  assign master_valid_o = (fill_q != '0) &&
                          ((STORE_FWD == 0) || (bursts_q != '0) || full);

  assign push      = slave_valid_i && slave_ready_o;
  assign pop       = master_valid_o && master_ready_i;
  assign push_last = push && slave_last_i;
  assign pop_last  = pop && rd_beat[0];

  assign wr_beat = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
  assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = rd_beat;

  axi_buffer_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (BUFFER_DEPTH)
  ) u_ram (
    .clk_i     (clk_i),
    .test_en_i (test_en_i),
    .we_i      (push),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (wr_beat),
    .raddr_i   (rd_ptr_q),
    .rdata_o   (rd_beat)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    bursts_d = bursts_q;
    // Depth is a power of two, so pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
    case ({push_last, pop_last})
      2'b10:   bursts_d = bursts_q + CNT_W'(1);
      2'b01:   bursts_d = bursts_q - CNT_W'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      bursts_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      bursts_q <= bursts_d;
    end
  end

  assign fill_o   = fill_q;
  assign bursts_o = bursts_q;

endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// Bench for axi_r_burst_buffer: a cut-through and a store-and-forward instance against a queue model.
module tb_axi_r_burst_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        s_valid [2];
  logic [63:0] s_data  [2];
  logic [1:0]  s_resp  [2];
  logic [5:0]  s_user  [2];
  logic [3:0]  s_id    [2];
  logic        s_last  [2];
  logic        s_ready [2];
  logic        m_valid [2];
  logic [63:0] m_data  [2];
  logic [1:0]  m_resp  [2];
  logic [5:0]  m_user  [2];
  logic [3:0]  m_id    [2];
  logic        m_last  [2];
  logic        m_ready [2];
  logic [3:0]  fill    [2];
  logic [3:0]  bursts  [2];

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    axi_r_burst_buffer #(
      .ID_WIDTH     (4),
      .DATA_WIDTH   (64),
      .USER_WIDTH   (6),
      .BUFFER_DEPTH (DEPTH),
      .STORE_FWD    (g)
    ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .test_en_i      (1'b0),
      .slave_valid_i  (s_valid[g]),
      .slave_data_i   (s_data[g]),
      .slave_resp_i   (s_resp[g]),
      .slave_user_i   (s_user[g]),
      .slave_id_i     (s_id[g]),
      .slave_last_i   (s_last[g]),
      .slave_ready_o  (s_ready[g]),
      .master_valid_o (m_valid[g]),
      .master_data_o  (m_data[g]),
      .master_resp_o  (m_resp[g]),
      .master_user_o  (m_user[g]),
      .master_id_o    (m_id[g]),
      .master_last_o  (m_last[g]),
      .master_ready_i (m_ready[g]),
      .fill_o         (fill[g]),
      .bursts_o       (bursts[g])
    );

    // Model: an ordered list of beats {id, user, data, resp, last}.
    logic [76:0] mq [$];

    function automatic int n_lasts();
      int n = 0;
      foreach (mq[i]) n += int'(mq[i][0]);
      return n;
    endfunction

    function automatic bit exp_valid();
      return (mq.size() > 0) && (g == 0 || n_lasts() > 0 || mq.size() == DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mq.delete();
      end else begin
        bit do_push, do_pop;
        do_push = s_valid[g] && (mq.size() < DEPTH);
        do_pop  = m_ready[g] && exp_valid();
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({s_id[g], s_user[g], s_data[g], s_resp[g], s_last[g]});
      end
    end

    always @(negedge clk) begin
      bit ev;
      ev = exp_valid();
      cmp($sformatf("i%0d_m_valid", g), 128'(m_valid[g]), 128'(ev));
      cmp($sformatf("i%0d_s_ready", g), 128'(s_ready[g]), 128'(mq.size() < DEPTH));
      cmp($sformatf("i%0d_fill", g), 128'(fill[g]), 128'(mq.size()));
      cmp($sformatf("i%0d_bursts", g), 128'(bursts[g]), 128'(n_lasts()));
      if (ev) begin
        cmp($sformatf("i%0d_m_id", g),   128'(m_id[g]),   128'(mq[0][76:73]));
        cmp($sformatf("i%0d_m_user", g), 128'(m_user[g]), 128'(mq[0][72:67]));
        cmp($sformatf("i%0d_m_data", g), 128'(m_data[g]), 128'(mq[0][66:3]));
        cmp($sformatf("i%0d_m_resp", g), 128'(m_resp[g]), 128'(mq[0][2:1]));
        cmp($sformatf("i%0d_m_last", g), 128'(m_last[g]), 128'(mq[0][0]));
      end
    end
  end

  task automatic drv(input int k, input bit v, input logic [3:0] id,
                     input logic [63:0] d, input bit last);
    s_valid[k] = v;
    s_id[k]    = id;
    s_data[k]  = d;
    s_last[k]  = last;
    s_user[k]  = {2'b00, id} ^ 6'h2A;
    s_resp[k]  = d[1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k);
    int n = 0;
    drv(k, 1'b0, 4'h0, 64'h0, 1'b0);
    m_ready[k] = 1'b1;
    while (fill[k] != 4'd0 && n < 40) begin
      step();
      n++;
    end
    cmp($sformatf("drain%0d_fill", k), 128'(fill[k]), 128'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    bit acc;
    bit raised;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv(k, 1'b0, 4'h0, 64'h0, 1'b0);
      m_ready[k] = 1'b0;
    end
    step();
    step();
    cmp("rst_m_valid", 128'(m_valid[0]), 128'd0);
    cmp("rst_s_ready", 128'(s_ready[0]), 128'd1);
    cmp("rst_fill",    128'(fill[0]),    128'd0);
    cmp("rst_bursts",  128'(bursts[1]),  128'd0);
    rst_n = 1'b1;
    step();

    // Cut-through: three back-to-back beats, ready high.
    m_ready[0] = 1'b1;
    drv(0, 1'b1, 4'h1, 64'hA1, 1'b0);
    cmp("ct_no_bypass", 128'(m_valid[0]), 128'd0);
    step();
    cmp("ct_b1_valid", 128'(m_valid[0]), 128'd1);
    cmp("ct_b1_data",  128'(m_data[0]),  128'hA1);
    cmp("ct_b1_id",    128'(m_id[0]),    128'h1);
    drv(0, 1'b1, 4'h2, 64'hA2, 1'b0);
    step();
    cmp("ct_b2_data", 128'(m_data[0]), 128'hA2);
    cmp("ct_b2_fill", 128'(fill[0]),   128'd1);
    drv(0, 1'b1, 4'h3, 64'hA3, 1'b1);
    step();
    cmp("ct_b3_data",   128'(m_data[0]), 128'hA3);
    cmp("ct_b3_bursts", 128'(bursts[0]), 128'd1);
    drv(0, 1'b0, 4'h0, 64'h0, 1'b0);
    step();
    cmp("ct_end_fill",  128'(fill[0]),    128'd0);
    cmp("ct_end_valid", 128'(m_valid[0]), 128'd0);

    // Store-and-forward: 4-beat burst is held until its last beat.
    m_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, 4'(4 + i), 64'hB0 + 64'(i), i == 3);
      step();
      if (i < 3) begin
        cmp($sformatf("sf_hold%0d_valid", i), 128'(m_valid[1]), 128'd0);
        cmp($sformatf("sf_hold%0d_fill", i),  128'(fill[1]),    128'(i + 1));
      end
    end
    cmp("sf_rel_valid",  128'(m_valid[1]), 128'd1);
    cmp("sf_rel_bursts", 128'(bursts[1]),  128'd1);
    cmp("sf_rel_data",   128'(m_data[1]),  128'hB0);
    drv(1, 1'b0, 4'h0, 64'h0, 1'b0);
    step();
    cmp("sf_pop1_bursts", 128'(bursts[1]), 128'd1);
    step();
    step();
    step();
    cmp("sf_pop4_bursts", 128'(bursts[1]), 128'd0);
    cmp("sf_pop4_fill",   128'(fill[1]),   128'd0);

    // Store-and-forward: 12-beat burst exceeds depth and forces release.
    m_ready[1] = 1'b0;
    sent = 0;
    cyc = 0;
    raised = 1'b0;
    while (sent < 12 && cyc < 100) begin
      drv(1, 1'b1, 4'(sent), 64'hC00 + 64'(sent), sent == 11);
      acc = s_ready[1];
      step();
      cyc++;
      if (acc) sent++;
      if (sent == 8 && !raised) begin
        cmp("fr_fill",    128'(fill[1]),    128'd8);
        cmp("fr_s_ready", 128'(s_ready[1]), 128'd0);
        cmp("fr_m_valid", 128'(m_valid[1]), 128'd1);
        cmp("fr_m_data",  128'(m_data[1]),  128'hC00);
        m_ready[1] = 1'b1;
        raised = 1'b1;
      end
    end
    cmp("fr_all_sent", 128'(sent), 128'd12);
    drain(1);

    // Full with a pending beat and a single pop: no push in the pop cycle.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b1, 4'(i), 64'hD0 + 64'(i), 1'b0);
      step();
    end
    cmp("full_fill",    128'(fill[0]),    128'd8);
    cmp("full_s_ready", 128'(s_ready[0]), 128'd0);
    drv(0, 1'b1, 4'h8, 64'hD8, 1'b1);
    m_ready[0] = 1'b1;
    step();
    cmp("full_pop_fill",    128'(fill[0]),    128'd7);
    cmp("full_pop_s_ready", 128'(s_ready[0]), 128'd1);
    cmp("full_pop_head",    128'(m_data[0]),  128'hD1);
    m_ready[0] = 1'b0;
    step();
    cmp("full_refill", 128'(fill[0]), 128'd8);
    drain(0);

    // Simultaneous push(last) and pop(last) with two bursts stored.
    m_ready[1] = 1'b0;
    drv(1, 1'b1, 4'hE, 64'hE0, 1'b1);
    step();
    drv(1, 1'b1, 4'hE, 64'hE1, 1'b1);
    step();
    cmp("pp_pre_bursts", 128'(bursts[1]), 128'd2);
    cmp("pp_pre_fill",   128'(fill[1]),   128'd2);
    drv(1, 1'b1, 4'hE, 64'hE2, 1'b1);
    m_ready[1] = 1'b1;
    step();
    cmp("pp_bursts", 128'(bursts[1]), 128'd2);
    cmp("pp_fill",   128'(fill[1]),   128'd2);
    cmp("pp_head",   128'(m_data[1]), 128'hE1);
    drain(1);

    // Reset mid-operation with five beats stored.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b1, 4'(9 + i), 64'hF0 + 64'(i), i == 1);
      step();
    end
    drv(0, 1'b0, 4'h0, 64'h0, 1'b0);
    cmp("rm_pre_fill",   128'(fill[0]),   128'd5);
    cmp("rm_pre_bursts", 128'(bursts[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    cmp("rm_m_valid", 128'(m_valid[0]), 128'd0);
    cmp("rm_fill",    128'(fill[0]),    128'd0);
    cmp("rm_bursts",  128'(bursts[0]),  128'd0);
    step();
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp($sformatf("rm_post%0d_valid", i), 128'(m_valid[0]), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
